// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: ID-side inputs (stall/flush, control, operands) and the registered EX-side view.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              Stall;
    logic              Flush;
    logic              Valid_i;
    logic [8:0]        EX_i;
    logic [4:0]        M_i;
    logic [3:0]        WB_i;
    logic [DATA_W-1:0] PCPlus4_i;
    logic [DATA_W-1:0] RsData_i;
    logic [DATA_W-1:0] RtData_i;
    logic [DATA_W-1:0] Imm_i;
    logic [4:0]        Rs_i;
    logic [4:0]        Rt_i;
    logic [4:0]        Rd_i;
    logic [4:0]        Shamt_i;

    logic [8:0]        EX_o;
    logic [4:0]        M_o;
    logic [3:0]        WB_o;
    logic [DATA_W-1:0] PCPlus4_o;
    logic [DATA_W-1:0] RsData_o;
    logic [DATA_W-1:0] RtData_o;
    logic [DATA_W-1:0] Imm_o;
    logic [4:0]        Rs_o;
    logic [4:0]        Rt_o;
    logic [4:0]        Rd_o;
    logic [4:0]        Shamt_o;
    logic              Valid_o;
    logic [CNT_W-1:0]  BubbleCnt;

    modport master (
        output Stall, Flush, Valid_i, EX_i, M_i, WB_i,
               PCPlus4_i, RsData_i, RtData_i, Imm_i, Rs_i, Rt_i, Rd_i, Shamt_i,
        input  EX_o, M_o, WB_o, PCPlus4_o, RsData_o, RtData_o, Imm_o,
               Rs_o, Rt_o, Rd_o, Shamt_o, Valid_o, BubbleCnt
    );

    modport slave (
        input  Stall, Flush, Valid_i, EX_i, M_i, WB_i,
               PCPlus4_i, RsData_i, RtData_i, Imm_i, Rs_i, Rt_i, Rd_i, Shamt_i,
        output EX_o, M_o, WB_o, PCPlus4_o, RsData_o, RtData_o, Imm_o,
               Rs_o, Rt_o, Rd_o, Shamt_o, Valid_o, BubbleCnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: holds on stall, loads a zero-control bubble on flush,
// and keeps a saturating count of every bubble that enters EX.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    id_ex_stage_reg_if.slave  bus
);
    logic [8:0]       exReg;
    logic [4:0]       mReg;
    logic [3:0]       wbReg;
    logic             validReg;
    logic [CNT_W-1:0] bubbleCntReg;
    logic             bubbleNow;

    logic [3:0][DATA_W-1:0] dataIn;
    logic [3:0][DATA_W-1:0] dataOut;
    logic [3:0][4:0]        fldIn;
    logic [3:0][4:0]        fldOut;

    // A bubble enters EX either by flush or by an un-stalled load of an empty ID slot.
    assign bubbleNow = bus.Flush | (~bus.Stall & ~bus.Valid_i);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exReg    <= '0;
            mReg     <= '0;
            wbReg    <= '0;
            validReg <= 1'b0;
        end else if (bus.Flush) begin
            exReg    <= '0;
            mReg     <= '0;
            wbReg    <= '0;
            validReg <= 1'b0;
        end else if (!bus.Stall) begin
            exReg    <= bus.Valid_i ? bus.EX_i : '0;
            mReg     <= bus.Valid_i ? bus.M_i  : '0;
            wbReg    <= bus.Valid_i ? bus.WB_i : '0;
            validReg <= bus.Valid_i;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bubbleCntReg <= '0;
        end else if (bubbleNow && (bubbleCntReg != {CNT_W{1'b1}})) begin
            bubbleCntReg <= bubbleCntReg + 1'b1;
        end
    end

    assign dataIn[0] = bus.PCPlus4_i;
    assign dataIn[1] = bus.RsData_i;
    assign dataIn[2] = bus.RtData_i;
    assign dataIn[3] = bus.Imm_i;
    assign fldIn[0]  = bus.Rs_i;
    assign fldIn[1]  = bus.Rt_i;
    assign fldIn[2]  = bus.Rd_i;
    assign fldIn[3]  = bus.Shamt_i;

    // Operands and fields are zeroed on flush so nothing stale can be forwarded.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gStage
            logic [DATA_W-1:0] wordReg;
            logic [4:0]        fieldReg;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    wordReg  <= '0;
                    fieldReg <= '0;
                end else if (bus.Flush) begin
                    wordReg  <= '0;
                    fieldReg <= '0;
                end else if (!bus.Stall) begin
                    wordReg  <= dataIn[gi];
                    fieldReg <= fldIn[gi];
                end
            end

            assign dataOut[gi] = wordReg;
            assign fldOut[gi]  = fieldReg;
        end
    endgenerate

    assign bus.EX_o      = exReg;
    assign bus.M_o       = mReg;
    assign bus.WB_o      = wbReg;
    assign bus.Valid_o   = validReg;
    assign bus.BubbleCnt = bubbleCntReg;
    assign bus.PCPlus4_o = dataOut[0];
    assign bus.RsData_o  = dataOut[1];
    assign bus.RtData_o  = dataOut[2];
    assign bus.Imm_o     = dataOut[3];
    assign bus.Rs_o      = fldOut[0];
    assign bus.Rt_o      = fldOut[1];
    assign bus.Rd_o      = fldOut[2];
    assign bus.Shamt_o   = fldOut[3];
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed cases with literal expectations plus a random run
// compared every cycle against a behavioural model; a CNT_W=3 copy exercises saturation.
module tb_id_ex_stage_reg;
    localparam int DW = 32;

    logic Clk;
    logic Rst_n;
    logic stall, flush, validIn;
    logic [8:0]  exIn;
    logic [4:0]  mIn;
    logic [3:0]  wbIn;
    logic [DW-1:0] pcIn, rsDIn, rtDIn, immIn;
    logic [4:0]  rsIn, rtIn, rdIn, shIn;

    int checks = 0;
    int failures = 0;

    id_ex_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) busM ();
    id_ex_stage_reg_if #(.DATA_W(DW), .CNT_W(3))  busS ();

    assign busM.Stall = stall;     assign busS.Stall = stall;
    assign busM.Flush = flush;     assign busS.Flush = flush;
    assign busM.Valid_i = validIn; assign busS.Valid_i = validIn;
    assign busM.EX_i = exIn;       assign busS.EX_i = exIn;
    assign busM.M_i = mIn;         assign busS.M_i = mIn;
    assign busM.WB_i = wbIn;       assign busS.WB_i = wbIn;
    assign busM.PCPlus4_i = pcIn;  assign busS.PCPlus4_i = pcIn;
    assign busM.RsData_i = rsDIn;  assign busS.RsData_i = rsDIn;
    assign busM.RtData_i = rtDIn;  assign busS.RtData_i = rtDIn;
    assign busM.Imm_i = immIn;     assign busS.Imm_i = immIn;
    assign busM.Rs_i = rsIn;       assign busS.Rs_i = rsIn;
    assign busM.Rt_i = rtIn;       assign busS.Rt_i = rtIn;
    assign busM.Rd_i = rdIn;       assign busS.Rd_i = rdIn;
    assign busM.Shamt_i = shIn;    assign busS.Shamt_i = shIn;

    id_ex_stage_reg #(.DATA_W(DW), .CNT_W(16)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(busM));
    id_ex_stage_reg #(.DATA_W(DW), .CNT_W(3))  dutSat (.Clk(Clk), .Rst_n(Rst_n), .bus(busS));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: what EX must see, plus a plain integer bubble tally.
    logic [8:0]  expEx;
    logic [4:0]  expM;
    logic [3:0]  expWb;
    logic        expValid;
    logic        expKnown;
    logic [DW-1:0] expPc, expRsD, expRtD, expImm;
    logic [4:0]  expRs, expRt, expRd, expSh;
    int          bubbles;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            expEx <= '0; expM <= '0; expWb <= '0; expValid <= 1'b0; expKnown <= 1'b1;
            expPc <= '0; expRsD <= '0; expRtD <= '0; expImm <= '0;
            expRs <= '0; expRt <= '0; expRd <= '0; expSh <= '0;
            bubbles <= 0;
        end else if (flush) begin
            expEx <= '0; expM <= '0; expWb <= '0; expValid <= 1'b0; expKnown <= 1'b1;
            expPc <= '0; expRsD <= '0; expRtD <= '0; expImm <= '0;
            expRs <= '0; expRt <= '0; expRd <= '0; expSh <= '0;
            bubbles <= bubbles + 1;
        end else if (!stall) begin
            expValid <= validIn;
            expEx <= validIn ? exIn : 9'd0;
            expM  <= validIn ? mIn  : 5'd0;
            expWb <= validIn ? wbIn : 4'd0;
            expKnown <= validIn;
            expPc <= pcIn; expRsD <= rsDIn; expRtD <= rtDIn; expImm <= immIn;
            expRs <= rsIn; expRt <= rtIn; expRd <= rdIn; expSh <= shIn;
            if (!validIn) bubbles <= bubbles + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic int satTo(input int n, input int cntW);
        int top;
        top = (1 << cntW) - 1;
        return (n > top) ? top : n;
    endfunction

    always @(negedge Clk) begin
        chk("m_EX_o", 64'(busM.EX_o), 64'(expEx));
        chk("m_M_o", 64'(busM.M_o), 64'(expM));
        chk("m_WB_o", 64'(busM.WB_o), 64'(expWb));
        chk("m_Valid_o", 64'(busM.Valid_o), 64'(expValid));
        chk("m_BubbleCnt16", 64'(busM.BubbleCnt), 64'(satTo(bubbles, 16)));
        chk("m_BubbleCnt3", 64'(busS.BubbleCnt), 64'(satTo(bubbles, 3)));
        chk("m_sat_EX_o", 64'(busS.EX_o), 64'(expEx));
        if (expKnown) begin
            chk("m_PCPlus4_o", 64'(busM.PCPlus4_o), 64'(expPc));
            chk("m_RsData_o", 64'(busM.RsData_o), 64'(expRsD));
            chk("m_RtData_o", 64'(busM.RtData_o), 64'(expRtD));
            chk("m_Imm_o", 64'(busM.Imm_o), 64'(expImm));
            chk("m_fields", {44'd0, busM.Rs_o, busM.Rt_o, busM.Rd_o, busM.Shamt_o},
                {44'd0, expRs, expRt, expRd, expSh});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic randInputs();
        exIn = 9'($urandom); mIn = 5'($urandom); wbIn = 4'($urandom);
        pcIn = $urandom; rsDIn = $urandom; rtDIn = $urandom; immIn = $urandom;
        rsIn = 5'($urandom); rtIn = 5'($urandom); rdIn = 5'($urandom); shIn = 5'($urandom);
    endtask

    initial begin
        Rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; validIn = 1'b1;
        exIn = 9'h1FF; mIn = 5'h1F; wbIn = 4'hF;
        pcIn = 32'h1234_5678; rsDIn = 32'hFFFF_FFFF; rtDIn = 32'hA5A5_A5A5; immIn = 32'h0000_FFFF;
        rsIn = 5'd1; rtIn = 5'd2; rdIn = 5'd3; shIn = 5'd4;

        // Held in reset across an edge with every input nonzero.
        #12;
        chk("rst_EX_o", 64'(busM.EX_o), 64'h0);
        chk("rst_Valid_o", 64'(busM.Valid_o), 64'h0);
        chk("rst_BubbleCnt", 64'(busM.BubbleCnt), 64'h0);
        chk("rst_RsData_o", 64'(busM.RsData_o), 64'h0);
        Rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            randInputs();
            validIn = 1'b1;
            step();
        end
        chk("pre_async_Valid_o", 64'(busM.Valid_o), 64'h1);

        // Asynchronous reset between edges must clear outputs without a clock.
        #2 Rst_n = 1'b0;
        #1;
        chk("async_EX_o", 64'(busM.EX_o), 64'h0);
        chk("async_Valid_o", 64'(busM.Valid_o), 64'h0);
        chk("async_RsData_o", 64'(busM.RsData_o), 64'h0);
        chk("async_WB_o", 64'(busM.WB_o), 64'h0);
        step();
        Rst_n = 1'b1;

        // Load path.
        validIn = 1'b1; stall = 1'b0; flush = 1'b0;
        exIn = 9'h1A5; mIn = 5'h13; wbIn = 4'hA; rsDIn = 32'hDEADBEEF; rdIn = 5'd17;
        step();
        chk("load_EX_o", 64'(busM.EX_o), 64'h1A5);
        chk("load_M_o", 64'(busM.M_o), 64'h13);
        chk("load_WB_o", 64'(busM.WB_o), 64'hA);
        chk("load_RsData_o", 64'(busM.RsData_o), 64'hDEADBEEF);
        chk("load_Rd_o", 64'(busM.Rd_o), 64'd17);
        chk("load_Valid_o", 64'(busM.Valid_o), 64'h1);

        // Three stalled cycles with changing inputs.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randInputs();
            validIn = 1'($urandom);
            step();
            chk("stall_EX_o", 64'(busM.EX_o), 64'h1A5);
            chk("stall_RsData_o", 64'(busM.RsData_o), 64'hDEADBEEF);
            chk("stall_Valid_o", 64'(busM.Valid_o), 64'h1);
        end
        stall = 1'b0; validIn = 1'b1;
        exIn = 9'h0F3; rsDIn = 32'h0BAD_F00D;
        step();
        chk("unstall_EX_o", 64'(busM.EX_o), 64'h0F3);
        chk("unstall_RsData_o", 64'(busM.RsData_o), 64'h0BADF00D);

        // Flush wins over stall.
        flush = 1'b1; stall = 1'b1; validIn = 1'b1;
        exIn = 9'h155; mIn = 5'h0A; wbIn = 4'h5; rsDIn = 32'h1111_2222;
        step();
        chk("flush_EX_o", 64'(busM.EX_o), 64'h0);
        chk("flush_M_o", 64'(busM.M_o), 64'h0);
        chk("flush_WB_o", 64'(busM.WB_o), 64'h0);
        chk("flush_Valid_o", 64'(busM.Valid_o), 64'h0);
        chk("flush_RsData_o", 64'(busM.RsData_o), 64'h0);
        chk("flush_BubbleCnt", 64'(busM.BubbleCnt), 64'h1);

        // Invalid load zeroes control and counts a bubble.
        flush = 1'b0; stall = 1'b0; validIn = 1'b0; exIn = 9'h1FF;
        step();
        chk("inval_EX_o", 64'(busM.EX_o), 64'h0);
        chk("inval_Valid_o", 64'(busM.Valid_o), 64'h0);
        chk("inval_BubbleCnt", 64'(busM.BubbleCnt), 64'h2);

        // Saturation on the 3-bit counter: 9 consecutive flushes from reset.
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        flush = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k >= 7) chk("sat_BubbleCnt3", 64'(busS.BubbleCnt), 64'd7);
            chk("sat_BubbleCnt16", 64'(busM.BubbleCnt), 64'(k));
        end
        flush = 1'b0;

        // Randomized traffic, including long stall bursts and flush runs.
        for (int i = 0; i < 3000; i++) begin
            randInputs();
            validIn = ($urandom_range(0, 99) < 75);
            if (stall) stall = ($urandom_range(0, 99) < 70);
            else       stall = ($urandom_range(0, 99) < 25);
            flush = ($urandom_range(0, 99) < 12);
            step();
        end

        stall = 1'b0; flush = 1'b0;
        step();
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 5-stage MIPS datapath. It sits directly downstream of the Controller and register file. It captures the Controller's EX/M/WB control bundles and the decoded operands each cycle, and presents them to the EX stage. It supports pipeline stall (hold) and flush (bubble insertion), and keeps a saturating count of inserted bubbles for debug.

## Interface
- DATA_W, 32, datapath width (register data, immediate, PC+4)
- CNT_W, 16, width of bubble counter
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous, active-low reset
- Stall  input  1  hold all stage contents this cycle
- Flush  input  1  load a bubble (all control zero, Valid_o=0)
- Valid_i  input  1  ID stage holds a real instruction
- EX_i  input  9  Controller EX bundle
- M_i  input  5  Controller M bundle
- WB_i  input  4  Controller WB bundle
- PCPlus4_i  input  DATA_W  PC+4 of instruction in ID
- RsData_i, RtData_i  input  DATA_W each  register file read data
- Imm_i  input  DATA_W  sign/zero-extended immediate
- Rs_i, Rt_i, Rd_i, Shamt_i  input  5 each  instruction fields
- EX_o, M_o, WB_o  output  9/5/4  registered control bundles
- PCPlus4_o, RsData_o, RtData_o, Imm_o  output  DATA_W each  registered data
- Rs_o, Rt_o, Rd_o, Shamt_o  output  5 each  registered fields
- Valid_o  output  1  EX stage holds a real instruction
- BubbleCnt  output  CNT_W  bubbles inserted since reset, saturating

## Operation
- Reset (Rst_n=0, asynchronous): every output and internal register goes to 0 immediately. This includes EX_o, M_o, WB_o, Valid_o, and BubbleCnt. Registers stay at 0 while Rst_n is low.
- Per rising edge of Clk with Rst_n=1, priority is Flush > Stall > Load.
  - Flush=1: EX_o, M_o, WB_o and Valid_o are set to 0. Data and field registers also load 0, so no stale operand is forwarded. BubbleCnt increments by 1. Flush wins even if Stall=1 in the same cycle; this is the load-use case, where IF/ID holds and ID/EX gets a bubble.
  - Flush=0, Stall=1: all registers hold their values. BubbleCnt is unchanged.
  - Flush=0, Stall=0: all registers load their inputs.
    - Valid_o takes Valid_i.
    - If Valid_i=0, control bundles load 0 regardless of EX_i/M_i/WB_i. Data registers still load, and they are don't-care.
    - If Valid_i=0 in a load cycle, BubbleCnt increments by 1.
- BubbleCnt saturates at 2^CNT_W−1 and never wraps to 0.
- Control bundles are passed bit-exact. The block does not reinterpret Controller encodings.
- A zero control bundle must be a safe NOP downstream: no register write, no memory access, no branch.
- The block contains no combinational path from any input to any output. All outputs come straight from registers.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and stay valid until edge N+1.
- Stall can be held for any number of cycles. Outputs stay frozen for the whole stall.
- On the first un-stalled edge after a stall, the block loads whatever is on the inputs at that edge.
- Flush is a single-edge action. A Flush held for k cycles inserts k bubbles, and BubbleCnt rises by k (saturating).
- Reset mid-operation: outputs clear asynchronously, with no need for a clock edge. On the first edge after Rst_n rises, the normal priority rules apply.
- Rst_n deassertion is assumed synchronous to Clk at system level. The block contains no reset synchronizer.

## Test plan
- Reset with all inputs at nonzero values, then Rst_n=0 between clock edges. All outputs must be 0 before the next edge, and BubbleCnt=0.
- Load path: EX_i=9'h1A5, M_i=5'h13, WB_i=4'hA, RsData_i=32'hDEADBEEF, Rd_i=5'd17, Valid_i=1. After one edge the outputs must equal these values and Valid_o=1.
- Stall for 3 cycles while the inputs change every cycle. Outputs must hold the pre-stall values. After Stall drops, the next edge loads the current inputs.
- Flush=1 and Stall=1 together with valid nonzero inputs. After the edge, EX_o/M_o/WB_o=0, Valid_o=0, data=0, and BubbleCnt=1.
- Load with Valid_i=0 and EX_i=9'h1FF. After the edge, EX_o=0, Valid_o=0, and BubbleCnt increments.
- Saturation with CNT_W=3: apply 9 consecutive Flush edges. BubbleCnt must read 7 after the 7th, 8th and 9th edges.
